bias_relu_streamer: RTL and testbench

//  Downstream stage of matrix_dot_product in the layer datapath.
//  - Accepts one full M x N product matrix plus an N-entry per-column bias vector.
//  - Adds the bias with saturation, applies ReLU, and streams the results one element per beat
//    (row-major) over a valid/ready handshake to the next layer or the output buffer.
//  - Fixed-point signed Qi.f throughout: DATA_W total bits, FRAC_W fractional bits.

---
 rtl/nn_fixed_pkg.sv | 32 +++
 rtl/fix_bias_relu.sv | 33 +++
 rtl/bias_relu_streamer.sv | 131 +++++++++++++
 tb/tb_bias_relu_streamer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point types and helpers for the layer datapath.
// Qi.f signed format, saturating add, ReLU and streamer FSM states.
package nn_fixed_pkg;

  localparam int FIX_W    = 16;
  localparam int FIX_FRAC = 8;

  typedef logic signed [FIX_W-1:0] fix_t;

  localparam fix_t FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};
  localparam fix_t FIX_MIN = {1'b1, {(FIX_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    STREAM
  } stream_state_t;

  function automatic fix_t sat_add(fix_t a, fix_t b);
    logic signed [FIX_W:0] s;
    s = {a[FIX_W-1], a} + {b[FIX_W-1], b};
    // top two bits disagree -> result left the representable range
    if (s[FIX_W] != s[FIX_W-1])
      return s[FIX_W] ? FIX_MIN : FIX_MAX;
    return fix_t'(s[FIX_W-1:0]);
  endfunction

  function automatic fix_t relu(fix_t x);
    return x[FIX_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/fix_bias_relu.sv
// Combinational a + bias with saturation and optional ReLU.
// Ports: a, b (DATA_W signed operands) -> y (DATA_W result).
module fix_bias_relu
  import nn_fixed_pkg::*;
#(
  parameter int DATA_W  = FIX_W,
  parameter bit RELU_EN = 1'b1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] VMAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] VMIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sat;

  always_comb begin
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    sat = sum[DATA_W-1:0];
    // overflow when the extra sign bit disagrees
    if (sum[DATA_W] != sum[DATA_W-1])
      sat = sum[DATA_W] ? VMIN : VMAX;
    y = sat;
    if (RELU_EN && sat[DATA_W-1])
      y = '0;
  end

endmodule

// File: rtl/bias_relu_streamer.sv
// Captures an M x N product matrix plus column bias and streams
// relu(sat(a+bias)) row-major, one beat per cycle, over valid/ready.
// Ports: clk, reset, in_valid/in_ready/in_matrix/bias (capture side),
// out_valid/out_ready/out_data/out_index/out_last (stream side), busy.
module bias_relu_streamer
  import nn_fixed_pkg::*;
#(
  parameter int M       = 2,
  parameter int N       = 2,
  parameter int DATA_W  = FIX_W,
  parameter int FRAC_W  = FIX_FRAC,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [M*N*DATA_W-1:0] in_matrix,
  input  logic [N*DATA_W-1:0]   bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [((M*N>1)?$clog2(M*N):1)-1:0] out_index,
  output logic                  out_last,
  output logic                  busy
);

  localparam int E  = M * N;
  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (FRAC_W >= DATA_W) begin : g_bad_fmt
    $error("FRAC_W must be smaller than DATA_W");
  end

  stream_state_t state_q, state_d;

  logic [E*DATA_W-1:0] mat_q;
  logic [N*DATA_W-1:0] bias_q;
  logic [CW-1:0]       col_q;

  logic [IW-1:0]     sel;
  logic [CW-1:0]     csel;
  logic [DATA_W-1:0] elem;
  logic [DATA_W-1:0] bcol;
  logic [DATA_W-1:0] res;
  logic              hs;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign hs       = out_valid && out_ready;

  // PREP loads element 0; STREAM preloads the element after the
  // current beat so the next value is ready at the handshake edge
  always_comb begin
    sel  = '0;
    csel = '0;
    if (state_q == STREAM) begin
      sel  = out_index + IW'(1);
      csel = (col_q == CW'(N-1)) ? '0 : col_q + CW'(1);
    end
  end

  assign elem = mat_q[int'(sel)*DATA_W +: DATA_W];
  assign bcol = bias_q[int'(csel)*DATA_W +: DATA_W];

  fix_bias_relu #(
    .DATA_W  (DATA_W),
    .RELU_EN (RELU_EN)
  ) u_fbr (
    .a (elem),
    .b (bcol),
    .y (res)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = STREAM;
      STREAM:  if (hs && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mat_q     <= '0;
      bias_q    <= '0;
      col_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mat_q  <= in_matrix;
            bias_q <= bias;
          end
        end
        PREP: begin
          out_valid <= 1'b1;
          out_data  <= res;
          out_index <= '0;
          out_last  <= (E == 1);
          col_q     <= '0;
        end
        STREAM: begin
          if (hs && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (hs) begin
            out_data  <= res;
            out_index <= sel;
            out_last  <= (sel == IW'(E-1));
            col_q     <= csel;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_relu_streamer.sv
// Self-checking bench for bias_relu_streamer (M=N=2, Q8.8).
// Two instances (RELU_EN=1 and 0) share stimulus; scoreboard per DUT.
module tb_bias_relu_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_matrix;
  logic [31:0] bias;
  logic        out_ready;

  logic        in_ready1, in_ready0;
  logic        out_valid1, out_valid0;
  logic [15:0] out_data1, out_data0;
  logic [1:0]  out_index1, out_index0;
  logic        out_last1, out_last0;
  logic        busy1, busy0;

  always #5 clk = ~clk;

  bias_relu_streamer #(
    .M(2), .N(2), .DATA_W(16), .FRAC_W(8), .RELU_EN(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_matrix(in_matrix), .bias(bias),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_index(out_index1),
    .out_last(out_last1), .busy(busy1)
  );

  bias_relu_streamer #(
    .M(2), .N(2), .DATA_W(16), .FRAC_W(8), .RELU_EN(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_matrix(in_matrix), .bias(bias),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_index(out_index0),
    .out_last(out_last0), .busy(busy0)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [3:0][15:0] mat;
    logic [1:0][15:0] b;
    logic [3:0][15:0] e1;
    logic [3:0][15:0] e0;
  } vec_t;

  beat_t q1[$];
  beat_t q0[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_hs_cyc = -10;
  int acc_cyc = 0;
  int rmode = 0;
  int pi = 0;
  int pat[6] = '{1, 0, 0, 1, 0, 1};

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(logic [15:0] a,
                                        logic [15:0] b,
                                        bit rl);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (rl && s < 0) s = 0;
    return s[15:0];
  endfunction

  // out_ready pattern generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = pat[pi % 6] != 0;
          pi = pi + 1;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: scoreboard, stall stability, in_ready after last
  logic        stall_p = 1'b0;
  logic        lasths_p = 1'b0;
  logic [15:0] hd1, hd0;
  logic [1:0]  hi1;
  logic        hl1;
  beat_t       eb;

  always @(negedge clk) begin
    if (reset) begin
      stall_p  = 1'b0;
      lasths_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("stall_valid", 32'(out_valid1), 32'd1);
        check("stall_data1", 32'(out_data1), 32'(hd1));
        check("stall_data0", 32'(out_data0), 32'(hd0));
        check("stall_index", 32'(out_index1), 32'(hi1));
        check("stall_last", 32'(out_last1), 32'(hl1));
      end
      if (lasths_p) begin
        check("ready_after_last", 32'(in_ready1), 32'd1);
        check("valid_after_last", 32'(out_valid1), 32'd0);
      end
      if (busy1)
        check("in_ready_busy", 32'(in_ready1), 32'd0);
      check("valid_pair", 32'(out_valid0), 32'(out_valid1));
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0 || q0.size() == 0) begin
          check("unexpected_beat", 32'(out_index1), 32'hFFFF);
        end else begin
          eb = q1.pop_front();
          check("data1", 32'(out_data1), 32'(eb.d));
          check("index", 32'(out_index1), 32'(eb.idx));
          check("last", 32'(out_last1), 32'(eb.last));
          eb = q0.pop_front();
          check("data0", 32'(out_data0), 32'(eb.d));
          check("index0", 32'(out_index0), 32'(eb.idx));
        end
        if (out_last1) last_hs_cyc = cyc + 1;
      end
      lasths_p = out_valid1 && out_ready && out_last1;
      stall_p  = out_valid1 && !out_ready;
      hd1 = out_data1;
      hd0 = out_data0;
      hi1 = out_index1;
      hl1 = out_last1;
    end
  end

  // call at a negedge; returns at the negedge after first out_valid
  task automatic send(vec_t v, bit hold);
    int n;
    in_matrix = v.mat;
    bias      = v.b;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready1 && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!in_ready1) begin
      check("accept_timeout", 32'(in_ready1), 32'd1);
      in_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      q1.push_back('{v.e1[k], 2'(k), k == 3});
      q0.push_back('{v.e0[k], 2'(k), k == 3});
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    in_matrix = {$urandom, $urandom};
    bias      = $urandom;
    @(negedge clk);
    check("prep_valid", 32'(out_valid1), 32'd0);
    check("prep_busy", 32'(busy1), 32'd1);
    check("prep_in_ready", 32'(in_ready1), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(out_valid1), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || busy1) && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    if (q1.size() != 0 || busy1) begin
      check("drain_timeout", 32'(q1.size()), 32'd0);
      q1.delete();
      q0.delete();
    end
  endtask

  vec_t vt[3];
  vec_t rv;

  initial begin
    vt[0].mat = {16'h1600, 16'h0F00, 16'h0A00, 16'h0700};
    vt[0].b   = {16'hF400, 16'h0100};
    vt[0].e1  = {16'h0A00, 16'h1000, 16'h0000, 16'h0800};
    vt[0].e0  = {16'h0A00, 16'h1000, 16'hFE00, 16'h0800};
    vt[1].mat = {16'h0100, 16'h0000, 16'h8100, 16'h7F00};
    vt[1].b   = {16'h8000, 16'h0200};
    vt[1].e1  = {16'h0000, 16'h0200, 16'h0000, 16'h7FFF};
    vt[1].e0  = {16'h8100, 16'h0200, 16'h8000, 16'h7FFF};
    vt[2].mat = {16'h7FFF, 16'h8000, 16'h0080, 16'hFF00};
    vt[2].b   = {16'h8000, 16'h7FFF};
    vt[2].e1  = {16'h0000, 16'h0000, 16'h0000, 16'h7EFF};
    vt[2].e0  = {16'hFFFF, 16'hFFFF, 16'h8080, 16'h7EFF};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_matrix = '0;
    bias      = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready1), 32'd1);
    check("rst_out_valid", 32'(out_valid1), 32'd0);
    check("rst_out_data", 32'(out_data1), 32'd0);
    check("rst_out_index", 32'(out_index1), 32'd0);
    check("rst_out_last", 32'(out_last1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);

    // table vectors, full throughput then backpressure
    for (int m = 0; m < 2; m++) begin
      rmode = m;
      for (int i = 0; i < 3; i++) begin
        send(vt[i], 1'b0);
        drain();
      end
    end

    // random vectors with random out_ready
    rmode = 2;
    for (int i = 0; i < 4; i++) begin
      rv.mat = {$urandom, $urandom};
      rv.b   = $urandom;
      for (int k = 0; k < 4; k++) begin
        rv.e1[k] = model(rv.mat[k], rv.b[k % 2], 1'b1);
        rv.e0[k] = model(rv.mat[k], rv.b[k % 2], 1'b0);
      end
      send(rv, 1'b0);
      drain();
    end

    // reset after beat 1
    rmode = 0;
    send(vt[0], 1'b0);
    for (int n = 0; n < 20; n++) begin
      if (out_valid1 && out_index1 == 2'd1) break;
      @(negedge clk);
    end
    check("beat1_seen", 32'(out_index1), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    q1.delete();
    q0.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid1), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready1), 32'd1);
    check("mid_rst_busy", 32'(busy1), 32'd0);
    send(vt[1], 1'b0);
    drain();

    // back-to-back with in_valid held high
    send(vt[0], 1'b1);
    send(vt[2], 1'b0);
    check("b2b_accept_cycle", 32'(acc_cyc), 32'(last_hs_cyc + 1));
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
